// File: rtl/otter_fetch_unit.sv
// rtl/otter_fetch_unit.sv - OTTER instruction fetch: PC generator, pipelined imem port, {PC,IR} prefetch FIFO
module otter_fetch_unit #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            FETCH_EN,
    input  logic            REDIRECT,
    input  logic [XLEN-1:0] REDIRECT_PC,
    output logic            IMEM_REQ,
    output logic [XLEN-1:0] IMEM_ADDR,
    input  logic            IMEM_GNT,
    input  logic            IMEM_RVALID,
    input  logic [XLEN-1:0] IMEM_RDATA,
    output logic            IF_VALID,
    output logic [XLEN-1:0] IF_PC,
    output logic [XLEN-1:0] IF_IR,
    input  logic            DE_READY
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   kill;
    logic [CW-1:0]   count;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [XLEN-1:0] pc_mem [DEPTH];
    logic [XLEN-1:0] ir_mem [DEPTH];

    logic [CW:0]     occupancy;
    logic            credit;
    logic            grant;
    logic            rsp;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_aligned;

    // FIFO slots are reserved at request time, so a granted fetch always has room to land.
    assign occupancy        = {1'b0, count} + {1'b0, outstanding};
    assign credit           = occupancy < (CW+1)'(DEPTH);
    assign redirect_aligned = REDIRECT_PC & ~XLEN'(3);

    assign IMEM_REQ  = RESET_N && FETCH_EN && credit && !REDIRECT;
    assign IMEM_ADDR = fetch_pc;
    assign grant     = IMEM_REQ && IMEM_GNT;
    assign rsp       = IMEM_RVALID && (outstanding != '0);
    assign push      = rsp && (kill == '0) && !REDIRECT;

    assign IF_VALID = (count != '0) && !REDIRECT;
    assign IF_PC    = pc_mem[rd_ptr];
    assign IF_IR    = ir_mem[rd_ptr];
    assign pop      = IF_VALID && DE_READY;

    always_comb begin
        outstanding_next = outstanding;
        if (grant && !rsp) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!grant && rsp) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fetch_pc    <= RESET_VEC;
            resp_pc     <= RESET_VEC;
            outstanding <= '0;
            kill        <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i] <= '0;
                ir_mem[i] <= '0;
            end
        end else begin
            outstanding <= outstanding_next;
            if (REDIRECT) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc <= redirect_aligned;
                resp_pc  <= redirect_aligned;
                kill     <= outstanding_next;
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (rsp && (kill != '0)) begin
                    kill <= kill - CW'(1);
                end
                if (push) begin
                    pc_mem[wr_ptr] <= resp_pc;
                    ir_mem[wr_ptr] <= IMEM_RDATA;
                    wr_ptr         <= wr_ptr + AW'(1);
                    resp_pc        <= resp_pc + XLEN'(4);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (!push && pop) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_otter_fetch_unit.sv
// tb/tb_otter_fetch_unit.sv - directed bench for otter_fetch_unit with an in-order latency memory model
module tb_otter_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        FETCH_EN = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic        IF_VALID;
    logic [31:0] IF_PC;
    logic [31:0] IF_IR;
    logic        DE_READY = 1'b0;

    otter_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_VEC(32'h0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .FETCH_EN(FETCH_EN), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_IR(IF_IR), .DE_READY(DE_READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          dly;
    } pend_t;

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } redir_vec_t;

    pend_t       q[$];
    redir_vec_t  vecs[4];
    int          lat = 1;
    int          errors = 0;
    int          checks = 0;
    int          n_grants = 0;
    int          n_pops = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_pc = '0;
    logic        o_req, o_valid;
    logic [31:0] o_addr, o_pc, o_ir;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample, score, advance the memory model.
    task automatic tick();
        logic g;
        logic rv;
        rv = (q.size() > 0) && (q[0].dly == 0);
        IMEM_RVALID = rv;
        if (rv) IMEM_RDATA = mem_word(q[0].addr);
        else    IMEM_RDATA = 32'hBAD0_BAD0;
        #1;
        o_req   = IMEM_REQ;
        o_addr  = IMEM_ADDR;
        o_valid = IF_VALID;
        o_pc    = IF_PC;
        o_ir    = IF_IR;
        g = IMEM_REQ && IMEM_GNT;
        if (REDIRECT) begin
            chk("redir_if_valid", {31'b0, IF_VALID}, 32'd0);
            chk("redir_req", {31'b0, IMEM_REQ}, 32'd0);
        end
        if (g) begin
            chk("req_addr", IMEM_ADDR, exp_addr);
            exp_addr = exp_addr + 32'd4;
            n_grants++;
        end
        if (IF_VALID && DE_READY) begin
            chk("pop_pc", IF_PC, exp_pc);
            chk("pop_ir", IF_IR, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (REDIRECT) begin
            exp_addr = REDIRECT_PC & ~32'h3;
            exp_pc   = REDIRECT_PC & ~32'h3;
        end
        @(posedge CLK);
        if (rv) void'(q.pop_front());
        foreach (q[i]) if (q[i].dly > 0) q[i].dly--;
        if (g) q.push_back('{addr: o_addr, dly: lat - 1});
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        REDIRECT = 1'b0;
        IMEM_RVALID = 1'b0;
        q.delete();
        exp_addr = '0;
        exp_pc = '0;
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    // Ticks until IF_VALID is seen; returns ticks before it, or -1 on timeout.
    task automatic wait_valid(input int max, output int k);
        k = -1;
        for (int i = 0; i < max; i++) begin
            tick();
            if (o_valid) begin
                k = i;
                break;
            end
        end
        if (k < 0) begin
            errors++;
            checks++;
            $display("FAIL wait_valid: got timeout expected IF_VALID within %0d cycles", max);
        end
    endtask

    initial begin
        int first_valid;
        int k;

        vecs[0] = '{rpc: 32'h0000_0203, exp0: 32'h0000_0200, exp1: 32'h0000_0204};
        vecs[1] = '{rpc: 32'hFFFF_FFFC, exp0: 32'hFFFF_FFFC, exp1: 32'h0000_0000};
        vecs[2] = '{rpc: 32'h8000_0001, exp0: 32'h8000_0000, exp1: 32'h8000_0004};
        vecs[3] = '{rpc: 32'h7FFF_FFFE, exp0: 32'h7FFF_FFFC, exp1: 32'h8000_0000};

        // Reset state with fetch already enabled.
        FETCH_EN = 1'b1;
        IMEM_GNT = 1'b1;
        DE_READY = 1'b1;
        @(negedge CLK);
        #1;
        chk("rst_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("rst_addr", IMEM_ADDR, 32'h0);
        chk("rst_if_valid", {31'b0, IF_VALID}, 32'd0);
        chk("rst_if_pc", IF_PC, 32'h0);
        chk("rst_if_ir", IF_IR, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Streaming with 1-cycle memory.
        lat = 1;
        first_valid = -1;
        n_pops = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) chk("first_req_addr", o_addr, 32'h0);
            if (o_valid && first_valid < 0) first_valid = i;
        end
        chk("stream_first_valid", first_valid, 32'd2);
        chk("stream_pops", n_pops, 32'd18);

        // Decode stall fills FIFO + credits, then drains in order.
        do_reset();
        DE_READY = 1'b0;
        n_grants = 0;
        repeat (10) tick();
        chk("stall_grants", n_grants, 32'd4);
        chk("stall_req", {31'b0, o_req}, 32'd0);
        chk("stall_valid", {31'b0, o_valid}, 32'd1);
        chk("stall_pc", o_pc, 32'h0);
        DE_READY = 1'b1;
        n_pops = 0;
        repeat (12) tick();
        chk("drain_pops", n_pops, 32'd12);

        // 3-cycle memory, redirect with 3 outstanding.
        do_reset();
        lat = 3;
        repeat (3) tick();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0100;
        tick();
        REDIRECT = 1'b0;
        wait_valid(20, k);
        chk("l3_redir_latency", k, 32'd4);
        chk("l3_redir_pc", o_pc, 32'h100);
        chk("l3_redir_ir", o_ir, mem_word(32'h100));
        repeat (6) tick();

        // Redirect coinciding with a response and a pop, 2-cycle memory.
        do_reset();
        lat = 2;
        repeat (8) tick();
        chk("l2_steady_valid", {31'b0, o_valid}, 32'd1);
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0040;
        tick();
        REDIRECT = 1'b0;
        tick();
        chk("l2_post_redir_valid", {31'b0, o_valid}, 32'd0);
        wait_valid(20, k);
        chk("l2_redir_latency", k, 32'd2);
        chk("l2_redir_pc", o_pc, 32'h40);
        repeat (6) tick();

        // Redirect address alignment and PC wrap.
        lat = 1;
        for (int v = 0; v < 4; v++) begin
            REDIRECT = 1'b1;
            REDIRECT_PC = vecs[v].rpc;
            tick();
            REDIRECT = 1'b0;
            tick();
            chk("vec_req0", {31'b0, o_req}, 32'd1);
            chk("vec_addr0", o_addr, vecs[v].exp0);
            tick();
            chk("vec_addr1", o_addr, vecs[v].exp1);
            repeat (4) tick();
        end

        // Asynchronous reset mid-burst with 2 outstanding.
        do_reset();
        lat = 2;
        repeat (6) tick();
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, IMEM_REQ}, 32'd0);
        chk("mid_rst_addr", IMEM_ADDR, 32'h0);
        chk("mid_rst_valid", {31'b0, IF_VALID}, 32'd0);
        chk("mid_rst_pc", IF_PC, 32'h0);
        chk("mid_rst_ir", IF_IR, 32'h0);
        q.delete();
        IMEM_RVALID = 1'b0;
        exp_addr = '0;
        exp_pc = '0;
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        chk("restart_addr", o_addr, 32'h0);
        wait_valid(20, k);
        chk("restart_pc", o_pc, 32'h0);
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
